alu_rs_scheduler: RTL and testbench

- Reservation station and issue scheduler in front of the single integer ALU in the Tomasulo core.
- Buffers dispatched CAL/CALi/BRA/JUM micro-ops and snoops both CDB broadcasts (ALU, LSB) for pending operands.
- Selects one operand-complete entry per cycle and drives the ALU's registered input bundle.
- Sits between the dispatcher/decoder and the ALU. The ALU result returns to the ROB and to this block's CDB snoop port.

---
 rtl/alu_rs_scheduler.sv | 155 +++++++++++++++
 tb/tb_alu_rs_scheduler.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_rs_scheduler.sv
// rtl/alu_rs_scheduler.sv - ALU reservation station with dual-CDB wake-up and lowest-index issue
`ifndef ROB_SZ_LOG
`define ROB_SZ_LOG 3
`endif

module alu_rs_scheduler #(
    parameter int RS_SZ_LOG = 3
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rdy_in,
    input  logic                   clr_in,
    input  logic                   in_flg,
    input  logic [3:0]             in_opcode,
    input  logic [3:0]             in_optype,
    input  logic [31:0]            in_Vj,
    input  logic [31:0]            in_Vk,
    input  logic                   in_Qj_vld,
    input  logic                   in_Qk_vld,
    input  logic [`ROB_SZ_LOG:0]   in_Qj,
    input  logic [`ROB_SZ_LOG:0]   in_Qk,
    input  logic [31:0]            in_imm,
    input  logic [31:0]            in_pc,
    input  logic [`ROB_SZ_LOG:0]   in_rd,
    input  logic                   cdb_alu_flg,
    input  logic [`ROB_SZ_LOG:0]   cdb_alu_tag,
    input  logic [31:0]            cdb_alu_val,
    input  logic                   cdb_lsb_flg,
    input  logic [`ROB_SZ_LOG:0]   cdb_lsb_tag,
    input  logic [31:0]            cdb_lsb_val,
    output logic                   full,
    output logic                   run_flg,
    output logic [`ROB_SZ_LOG:0]   rd_fr,
    output logic [31:0]            Vj,
    output logic [31:0]            Vk,
    output logic [31:0]            imm,
    output logic [31:0]            pc,
    output logic [3:0]             opcode,
    output logic [3:0]             optype
);
    localparam int RS_SZ = 1 << RS_SZ_LOG;
    localparam int TW    = `ROB_SZ_LOG + 1;

    logic [RS_SZ-1:0] busy;
    logic [RS_SZ-1:0] qj_vld;
    logic [RS_SZ-1:0] qk_vld;
    logic [3:0]       e_opcode [RS_SZ];
    logic [3:0]       e_optype [RS_SZ];
    logic [31:0]      e_vj     [RS_SZ];
    logic [31:0]      e_vk     [RS_SZ];
    logic [31:0]      e_imm    [RS_SZ];
    logic [31:0]      e_pc     [RS_SZ];
    logic [TW-1:0]    e_qj     [RS_SZ];
    logic [TW-1:0]    e_qk     [RS_SZ];
    logic [TW-1:0]    e_rd     [RS_SZ];

    logic [RS_SZ-1:0]     ready;
    logic [RS_SZ_LOG-1:0] free_idx;
    logic [RS_SZ_LOG-1:0] sel_idx;
    logic                 sel_vld;

    assign full  = &busy;
    assign ready = busy & ~qj_vld & ~qk_vld;

    // Descending scan so the lowest index is the last (winning) assignment.
    always_comb begin
        free_idx = '0;
        sel_idx  = '0;
        for (int i = RS_SZ - 1; i >= 0; i--) begin
            if (!busy[i])
                free_idx = i[RS_SZ_LOG-1:0];
            if (ready[i])
                sel_idx = i[RS_SZ_LOG-1:0];
        end
        sel_vld = |ready;
    end

    // Returns {still_pending, value}; the ALU broadcast wins over the LSB on an identical tag.
    function automatic logic [32:0] snoop(input logic pend, input logic [TW-1:0] tag,
                                          input logic [31:0] val);
        if (pend && cdb_alu_flg && cdb_alu_tag == tag)
            return {1'b0, cdb_alu_val};
        else if (pend && cdb_lsb_flg && cdb_lsb_tag == tag)
            return {1'b0, cdb_lsb_val};
        else
            return {pend, val};
    endfunction

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            busy    <= '0;
            qj_vld  <= '0;
            qk_vld  <= '0;
            run_flg <= 1'b0;
            rd_fr   <= '0;
            Vj      <= '0;
            Vk      <= '0;
            imm     <= '0;
            pc      <= '0;
            opcode  <= '0;
            optype  <= '0;
            for (int i = 0; i < RS_SZ; i++) begin
                e_opcode[i] <= '0;
                e_optype[i] <= '0;
                e_vj[i]     <= '0;
                e_vk[i]     <= '0;
                e_imm[i]    <= '0;
                e_pc[i]     <= '0;
                e_qj[i]     <= '0;
                e_qk[i]     <= '0;
                e_rd[i]     <= '0;
            end
        end else if (!rdy_in) begin
            run_flg <= 1'b0;
        end else if (clr_in) begin
            busy    <= '0;
            run_flg <= 1'b0;
        end else begin
            for (int i = 0; i < RS_SZ; i++) begin
                if (busy[i]) begin
                    {qj_vld[i], e_vj[i]} <= snoop(qj_vld[i], e_qj[i], e_vj[i]);
                    {qk_vld[i], e_vk[i]} <= snoop(qk_vld[i], e_qk[i], e_vk[i]);
                end
            end

            if (sel_vld) begin
                run_flg       <= 1'b1;
                rd_fr         <= e_rd[sel_idx];
                Vj            <= e_vj[sel_idx];
                Vk            <= e_vk[sel_idx];
                imm           <= e_imm[sel_idx];
                pc            <= e_pc[sel_idx];
                opcode        <= e_opcode[sel_idx];
                optype        <= e_optype[sel_idx];
                busy[sel_idx] <= 1'b0;
            end else begin
                run_flg <= 1'b0;
            end

            // free_idx is never busy, so it cannot collide with the issuing slot.
            if (in_flg && !full) begin
                busy[free_idx]     <= 1'b1;
                e_opcode[free_idx] <= in_opcode;
                e_optype[free_idx] <= in_optype;
                e_imm[free_idx]    <= in_imm;
                e_pc[free_idx]     <= in_pc;
                e_qj[free_idx]     <= in_Qj;
                e_qk[free_idx]     <= in_Qk;
                e_rd[free_idx]     <= in_rd;
                {qj_vld[free_idx], e_vj[free_idx]} <= snoop(in_Qj_vld, in_Qj, in_Vj);
                {qk_vld[free_idx], e_vk[free_idx]} <= snoop(in_Qk_vld, in_Qk, in_Vk);
            end
        end
    end
endmodule

// File: tb/tb_alu_rs_scheduler.sv
// tb/tb_alu_rs_scheduler.sv - directed bench with a slot-level reference model of the ALU reservation station
`ifndef ROB_SZ_LOG
`define ROB_SZ_LOG 3
`endif

module tb_alu_rs_scheduler;
    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] TY_CAL = 4'd1;

    logic        clk_in = 1'b0;
    logic        rst_in, rdy_in, clr_in, in_flg;
    logic [3:0]  in_opcode, in_optype;
    logic [31:0] in_Vj, in_Vk, in_imm, in_pc;
    logic        in_Qj_vld, in_Qk_vld;
    logic [3:0]  in_Qj, in_Qk, in_rd;
    logic        cdb_alu_flg, cdb_lsb_flg;
    logic [3:0]  cdb_alu_tag, cdb_lsb_tag;
    logic [31:0] cdb_alu_val, cdb_lsb_val;
    logic        full, run_flg;
    logic [3:0]  rd_fr, opcode, optype;
    logic [31:0] Vj, Vk, imm, pc;

    int checks = 0;
    int errors = 0;

    alu_rs_scheduler #(.RS_SZ_LOG(3)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .clr_in(clr_in),
        .in_flg(in_flg), .in_opcode(in_opcode), .in_optype(in_optype),
        .in_Vj(in_Vj), .in_Vk(in_Vk), .in_Qj_vld(in_Qj_vld), .in_Qk_vld(in_Qk_vld),
        .in_Qj(in_Qj), .in_Qk(in_Qk), .in_imm(in_imm), .in_pc(in_pc), .in_rd(in_rd),
        .cdb_alu_flg(cdb_alu_flg), .cdb_alu_tag(cdb_alu_tag), .cdb_alu_val(cdb_alu_val),
        .cdb_lsb_flg(cdb_lsb_flg), .cdb_lsb_tag(cdb_lsb_tag), .cdb_lsb_val(cdb_lsb_val),
        .full(full), .run_flg(run_flg), .rd_fr(rd_fr), .Vj(Vj), .Vk(Vk),
        .imm(imm), .pc(pc), .opcode(opcode), .optype(optype)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: eight slots holding each op's state as the rules describe it.
    typedef struct {
        bit          busy;
        logic [3:0]  op, ty, qj, qk, rd;
        logic [31:0] vj, vk, imm, pc;
        bit          pj, pk;
    } slot_t;

    slot_t       m [8];
    bit          e_run;
    logic [3:0]  e_rd, e_op, e_ty;
    logic [31:0] e_vj, e_vk, e_imm, e_pc;

    function automatic logic [32:0] resolve(input bit p, input logic [3:0] q, input logic [31:0] v);
        if (!p)                                return {1'b0, v};
        if (cdb_alu_flg && cdb_alu_tag == q)   return {1'b0, cdb_alu_val};
        if (cdb_lsb_flg && cdb_lsb_tag == q)   return {1'b0, cdb_lsb_val};
        return {1'b1, v};
    endfunction

    function automatic bit m_full();
        int n = 0;
        for (int i = 0; i < 8; i++) n += m[i].busy ? 1 : 0;
        return n == 8;
    endfunction

    always @(posedge clk_in or posedge rst_in) begin
        int sel, fre;
        if (rst_in) begin
            for (int i = 0; i < 8; i++) m[i] = '{default: 0};
            e_run = 0; e_rd = 0; e_op = 0; e_ty = 0;
            e_vj = 0; e_vk = 0; e_imm = 0; e_pc = 0;
        end else if (!rdy_in) begin
            e_run = 0;
        end else if (clr_in) begin
            for (int i = 0; i < 8; i++) m[i].busy = 0;
            e_run = 0;
        end else begin
            sel = -1;
            fre = -1;
            for (int i = 0; i < 8; i++) begin
                if (sel < 0 && m[i].busy && !m[i].pj && !m[i].pk) sel = i;
                if (fre < 0 && !m[i].busy) fre = i;
            end
            for (int i = 0; i < 8; i++)
                if (m[i].busy) begin
                    {m[i].pj, m[i].vj} = resolve(m[i].pj, m[i].qj, m[i].vj);
                    {m[i].pk, m[i].vk} = resolve(m[i].pk, m[i].qk, m[i].vk);
                end
            e_run = (sel >= 0);
            if (sel >= 0) begin
                e_rd = m[sel].rd; e_op = m[sel].op; e_ty = m[sel].ty;
                e_vj = m[sel].vj; e_vk = m[sel].vk; e_imm = m[sel].imm; e_pc = m[sel].pc;
                m[sel].busy = 0;
            end
            if (in_flg && fre >= 0) begin
                m[fre].busy = 1;
                m[fre].op = in_opcode; m[fre].ty = in_optype; m[fre].rd = in_rd;
                m[fre].imm = in_imm; m[fre].pc = in_pc; m[fre].qj = in_Qj; m[fre].qk = in_Qk;
                {m[fre].pj, m[fre].vj} = resolve(in_Qj_vld, in_Qj, in_Vj);
                {m[fre].pk, m[fre].vk} = resolve(in_Qk_vld, in_Qk, in_Vk);
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(negedge clk_in) begin
        if (rst_in === 1'b0) begin
            chk("m_full", full, m_full());
            chk("m_run_flg", run_flg, e_run);
            chk("m_rd_fr", rd_fr, e_rd);
            chk("m_opcode", opcode, e_op);
            chk("m_optype", optype, e_ty);
            chk("m_Vj", Vj, e_vj);
            chk("m_Vk", Vk, e_vk);
            chk("m_imm", imm, e_imm);
            chk("m_pc", pc, e_pc);
        end
    end

    task automatic cyc();
        @(negedge clk_in);
    endtask

    task automatic idle();
        in_flg = 0; in_Qj_vld = 0; in_Qk_vld = 0;
        cdb_alu_flg = 0; cdb_lsb_flg = 0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic pj, input logic [3:0] qj,
                        input logic pk, input logic [3:0] qk, input logic [3:0] rd);
        in_flg = 1; in_opcode = op; in_optype = TY_CAL;
        in_Vj = vj; in_Vk = vk; in_Qj_vld = pj; in_Qj = qj; in_Qk_vld = pk; in_Qk = qk;
        in_rd = rd; in_imm = {24'd0, rd, 4'd0}; in_pc = 32'h1000 + {26'd0, rd, 2'd0};
    endtask

    task automatic alu_bc(input logic [3:0] tag, input logic [31:0] val);
        cdb_alu_flg = 1; cdb_alu_tag = tag; cdb_alu_val = val;
    endtask

    task automatic lsb_bc(input logic [3:0] tag, input logic [31:0] val);
        cdb_lsb_flg = 1; cdb_lsb_tag = tag; cdb_lsb_val = val;
    endtask

    initial begin
        logic [3:0] r;
        rst_in = 1; rdy_in = 1; clr_in = 0;
        in_opcode = 0; in_optype = 0; in_Vj = 0; in_Vk = 0; in_Qj = 0; in_Qk = 0;
        in_imm = 0; in_pc = 0; in_rd = 0;
        cdb_alu_tag = 0; cdb_alu_val = 0; cdb_lsb_tag = 0; cdb_lsb_val = 0;
        idle();
        cyc(); cyc();
        rst_in = 0;
        chk("reset_run_flg", run_flg, 0);
        chk("reset_full", full, 0);
        chk("reset_rd_fr", rd_fr, 0);
        chk("reset_Vj", Vj, 0);

        // Ready ADD: written at E0, issued at E1, single pulse.
        disp(OP_ADD, 5, 7, 0, 0, 0, 0, 3); cyc(); idle();
        chk("add_no_early_issue", run_flg, 0);
        cyc();
        chk("add_run_flg", run_flg, 1);
        chk("add_opcode", opcode, OP_ADD);
        chk("add_Vj", Vj, 5);
        chk("add_Vk", Vk, 7);
        chk("add_rd_fr", rd_fr, 3);
        chk("add_imm", imm, 32'h30);
        chk("add_pc", pc, 32'h100c);
        cyc();
        chk("add_single_pulse", run_flg, 0);

        // SUB waiting on tag 6, woken by the LSB broadcast two cycles later.
        disp(OP_SUB, 0, 3, 1, 6, 0, 0, 4); cyc(); idle();
        chk("sub_wait1", run_flg, 0);
        cyc();
        chk("sub_wait2", run_flg, 0);
        lsb_bc(6, 32'h10); cyc(); idle();
        chk("sub_no_bypass", run_flg, 0);
        cyc();
        chk("sub_run_flg", run_flg, 1);
        chk("sub_Vj", Vj, 32'h10);
        chk("sub_rd_fr", rd_fr, 4);
        cyc();

        // Forwarding at dispatch, and ALU priority over LSB on the same tag.
        disp(OP_ADD, 1, 0, 0, 0, 1, 2, 5); alu_bc(2, 9); cyc(); idle();
        cyc();
        chk("fwd_run_flg", run_flg, 1);
        chk("fwd_Vk", Vk, 9);
        disp(OP_ADD, 0, 4, 1, 7, 0, 0, 6); alu_bc(7, 32'hA); lsb_bc(7, 32'hB); cyc(); idle();
        cyc();
        chk("prio_Vj", Vj, 32'hA);
        cyc();

        // Fill all eight slots on tag 1; a ninth dispatch must be dropped.
        for (int i = 0; i < 8; i++) begin
            r = i[3:0];
            disp(OP_ADD, 0, 32'(i), 1, 1, 0, 0, r); cyc();
        end
        idle();
        chk("fill_full", full, 1);
        disp(OP_SUB, 1, 1, 0, 0, 0, 0, 15); cyc(); idle();
        chk("drop_full", full, 1);
        chk("drop_no_issue", run_flg, 0);
        alu_bc(1, 32'h55); cyc(); idle();
        chk("fill_no_bypass", run_flg, 0);
        for (int i = 0; i < 8; i++) begin
            cyc();
            chk("drain_run_flg", run_flg, 1);
            chk("drain_rd_fr", rd_fr, 32'(i));
            chk("drain_Vk", Vk, 32'(i));
            chk("drain_Vj", Vj, 32'h55);
        end
        cyc();
        chk("drain_end", run_flg, 0);
        chk("drain_not_full", full, 0);

        // Flush with four busy slots and a concurrent dispatch.
        for (int i = 0; i < 4; i++) begin
            r = 4'(8 + i);
            disp(OP_ADD, 0, 0, 1, 4, 0, 0, r); cyc();
        end
        disp(OP_ADD, 1, 2, 0, 0, 0, 0, 12); clr_in = 1; cyc(); clr_in = 0; idle();
        chk("flush_full", full, 0);
        chk("flush_run_flg", run_flg, 0);
        alu_bc(4, 32'h44); cyc(); idle();
        chk("flush_not_stored", run_flg, 0);
        cyc();
        chk("flush_no_wake", run_flg, 0);

        // rdy_in low freezes an eligible slot until it returns.
        disp(OP_ADD, 32'h77, 1, 0, 0, 0, 0, 13); cyc(); idle();
        rdy_in = 0; cyc();
        chk("stall_run_flg", run_flg, 0);
        rdy_in = 1; cyc();
        chk("stall_resume_run", run_flg, 1);
        chk("stall_resume_rd", rd_fr, 13);
        chk("stall_resume_Vj", Vj, 32'h77);

        // Asynchronous reset while three slots wait and an issue is in flight.
        for (int i = 1; i <= 3; i++) begin
            r = i[3:0];
            disp(OP_SUB, 0, 0, 1, 9, 0, 0, r); cyc();
        end
        disp(OP_ADD, 2, 2, 0, 0, 0, 0, 6); cyc(); idle();
        cyc();
        chk("prereset_run_flg", run_flg, 1);
        chk("prereset_full", full, 0);
        #2 rst_in = 1;
        #1;
        chk("async_reset_run_flg", run_flg, 0);
        chk("async_reset_full", full, 0);
        chk("async_reset_rd_fr", rd_fr, 0);
        cyc();
        rst_in = 0;
        disp(OP_ADD, 2, 3, 0, 0, 0, 0, 7); cyc(); idle();
        cyc();
        chk("post_reset_run", run_flg, 1);
        chk("post_reset_rd", rd_fr, 7);
        alu_bc(9, 32'h99); cyc(); idle();
        cyc();
        chk("post_reset_cleared", run_flg, 0);
        cyc();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
